line_buf_ctrl: RTL and testbench
================================

// Module: line_buf_ctrl
// PURPOSE
//  Drives two cascaded read-before-write line buffers (1-cycle read latency, ce-gated
//  dout) from a raster pixel stream and assembles 3-row vertical columns (top/mid/bot)
//  for the dark-channel/min-filter window stage. Replicates the top border on centre
//  row 0, and the bottom border on centre row HEIGHT-1 via an internal flush row.
// PARAMETERS
//  WIDTH       160  pixels per line (>=2); sets the line-buffer address range
//  HEIGHT      120  lines per frame (>=2)
//  DATA_WIDTH  8    bits per pixel
// PORTS
//  clk       in   1              rising-edge clock
//  rst_n     in   1              synchronous active-low reset
//  s_valid   in   1              input pixel valid
//  s_sof     in   1              first pixel of frame (qualified by s_valid)
//  s_data    in   DATA_WIDTH     input pixel
//  s_ready   out  1              input accepted when s_valid&s_ready
//  lb0_ce    out  1              line buffer 0 enable (combinational)
//  lb0_addr  out  $clog2(WIDTH)  line buffer 0 address (combinational)
//  lb0_din   out  DATA_WIDTH     line buffer 0 write data (combinational)
//  lb0_dout  in   DATA_WIDTH     line buffer 0 old data, row r-1
//  lb1_ce    out  1              line buffer 1 enable (registered)
//  lb1_addr  out  $clog2(WIDTH)  line buffer 1 address (registered)
//  lb1_din   out  DATA_WIDTH     line buffer 1 write data (= lb0_dout, pass-through)
//  lb1_dout  in   DATA_WIDTH     line buffer 1 old data, row r-2
//  m_valid   out  1              output column valid (single-cycle pulse per column)
//  m_top     out  DATA_WIDTH     pixel at centre row-1, column m_col
//  m_mid     out  DATA_WIDTH     pixel at centre row
//  m_bot     out  DATA_WIDTH     pixel at centre row+1
//  m_col     out  $clog2(WIDTH)  centre column
//  m_row     out  $clog2(HEIGHT) centre row
//  m_eof     out  1              with m_valid: last column of centre row HEIGHT-1
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE; all registered outputs 0 (m_*, lb1_*);
//    pipeline valids cleared; lb0_ce forced 0. RAM contents are not cleared (not needed).
//  - FSM:
//    IDLE:  s_ready=1; pixels without s_sof are dropped.
//           s_valid&s_sof -> FILL (that pixel is row 0, col 0).
//    FILL:  row 0 is written; no m_valid output. Last column -> RUN.
//    RUN:   rows 1..HEIGHT-1. Last column of row HEIGHT-1 -> FLUSH.
//    FLUSH: s_ready=0 for exactly WIDTH cycles. One pseudo-pixel per cycle:
//           lb0_ce=1, lb0_din=0, virtual row=HEIGHT. Last pseudo column -> IDLE.
//  - s_valid&s_sof in FILL or RUN: abort. That pixel restarts as row 0, col 0 (-> FILL).
//    In-flight pipeline columns still drain.
//  - Counters: col wraps WIDTH-1 -> 0 and increments row. Advance only on accept or
//    flush step. Gaps (s_valid=0) stall nothing downstream: lb ce=0 holds dout.
//  - Stage 0 (cycle t, accept col c):
//    lb0_ce=1, lb0_addr=c, lb0_din=s_data; capture pixel, c, r.
//  - Stage 1 (t+1): lb1_ce<=v0, lb1_addr<=c, lb1_din=lb0_dout (row r-1).
//    Capture mid=lb0_dout.
//  - Stage 2 (t+2): lb1_dout = row r-2. Output regs load at the t+2 edge, so m_* is
//    visible in cycle t+3: fixed 3-cycle latency from accept to m_valid.
//  - m_valid=1 only for r>=1. Output field values:
//      m_row = r-1, m_col = c
//      m_top = (r==1) ? mid : lb1_dout
//      m_mid = mid
//      m_bot = (r==HEIGHT) ? mid : pixel
//  - m_eof = m_valid & (m_row==HEIGHT-1) & (m_col==WIDTH-1).
//    Exactly WIDTH*HEIGHT m_valid pulses per complete frame.
// TESTING
//  1. WIDTH=4, HEIGHT=3; continuous frame, pixel=16*row+col, sof on the first pixel ->
//     12 m_valid pulses; (row0,col1): top=01, mid=01, bot=11;
//     (row1,col2): top=02, mid=12, bot=22.
//  2. Same frame with random s_valid gaps -> identical 12 output tuples, same order;
//     each m_valid exactly 3 cycles after its accept.
//  3. Flush -> s_ready=0 for exactly 4 cycles after pixel (2,3);
//     row2 outputs top=1c, mid=2c, bot=2c for c=0..3; m_eof only on (2,3).
//  4. Pixels with s_valid=1 and s_sof=0 in IDLE -> no lb0_ce, no m_valid.
//  5. s_sof reasserted at (1,2) -> restart: next 12 outputs match scenario 1 for new data;
//     no output carries m_row=2 of the aborted frame.
//  6. rst_n=0 for 1 cycle mid-RUN -> next cycle m_valid=0, lb1_ce=0, state IDLE;
//     a following full frame matches scenario 1.

Source files
------------

// File: rtl/line_buf_ctrl.sv
// Line-buffer sequencer that turns a raster pixel stream into 3-row columns (top/mid/bot).
// It drives two cascaded read-before-write line buffers and replicates the top and bottom borders.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for s_sof; pixels without s_sof are dropped
// ST_FILL  | writing row 0 into lb0; no columns emitted yet
// ST_RUN   | rows 1..HEIGHT-1; emits the column centred one row above
// ST_FLUSH | WIDTH pseudo-pixels (virtual row HEIGHT) to emit the last row
module line_buf_ctrl #(
   parameter int WIDTH      = 160,
   parameter int HEIGHT     = 120,
   parameter int DATA_WIDTH = 8,
   localparam int AW        = $clog2(WIDTH),
   localparam int RW        = $clog2(HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   input  logic                  s_sof,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  lb0_ce,
   output logic [AW-1:0]         lb0_addr,
   output logic [DATA_WIDTH-1:0] lb0_din,
   input  logic [DATA_WIDTH-1:0] lb0_dout,
   output logic                  lb1_ce,
   output logic [AW-1:0]         lb1_addr,
   output logic [DATA_WIDTH-1:0] lb1_din,
   input  logic [DATA_WIDTH-1:0] lb1_dout,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_top,
   output logic [DATA_WIDTH-1:0] m_mid,
   output logic [DATA_WIDTH-1:0] m_bot,
   output logic [AW-1:0]         m_col,
   output logic [RW-1:0]         m_row,
   output logic                  m_eof
);

   // Row counter must also hold the virtual flush row HEIGHT.
   localparam int CW = $clog2(HEIGHT + 1);
   localparam logic [AW-1:0] COL_LAST  = AW'(WIDTH - 1);
   localparam logic [CW-1:0] ROW_LAST  = CW'(HEIGHT - 1);
   localparam logic [CW-1:0] ROW_FLUSH = CW'(HEIGHT);

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_FLUSH} state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         col_q, col_d;
   logic [CW-1:0]         row_q, row_d;
   logic                  step, restart;
   logic [AW-1:0]         pix_col;
   logic [CW-1:0]         pix_row;
   logic [DATA_WIDTH-1:0] pix_data;

   logic                  v0_q, v0_d, v1_q, v1_d;
   logic [DATA_WIDTH-1:0] pix0_q, pix0_d, pix1_q, pix1_d, mid1_q, mid1_d;
   logic [AW-1:0]         c0_q, c0_d, c1_q, c1_d;
   logic [CW-1:0]         r0_q, r0_d, r1_q, r1_d;

   logic                  m_valid_q, m_valid_d, m_eof_q, m_eof_d;
   logic [DATA_WIDTH-1:0] m_top_q, m_top_d, m_mid_q, m_mid_d, m_bot_q, m_bot_d;
   logic [AW-1:0]         m_col_q, m_col_d;
   logic [RW-1:0]         m_row_q, m_row_d;

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      step     = 1'b0;
      restart  = 1'b0;
      pix_col  = col_q;
      pix_row  = row_q;
      pix_data = s_data;
      s_ready  = (state_q != ST_FLUSH);
      case (state_q)
         ST_IDLE: restart = s_valid & s_sof;
         ST_FILL, ST_RUN: begin
            if (s_valid & s_sof) begin
               restart = 1'b1;
            end else if (s_valid) begin
               step = 1'b1;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
                  if (state_q == ST_FILL) state_d = ST_RUN;
                  else if (row_q == ROW_LAST) state_d = ST_FLUSH;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            step     = 1'b1;
            pix_data = '0;
            if (col_q == COL_LAST) begin
               col_d   = '0;
               row_d   = '0;
               state_d = ST_IDLE;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A new frame start always wins, even mid-frame; older columns keep draining.
      if (restart) begin
         step    = 1'b1;
         pix_col = '0;
         pix_row = '0;
         col_d   = AW'(1);
         row_d   = '0;
         state_d = ST_FILL;
      end
   end

   assign lb0_ce   = step & rst_n;
   assign lb0_addr = pix_col;
   assign lb0_din  = pix_data;
   assign lb1_ce   = v0_q;
   assign lb1_addr = c0_q;
   assign lb1_din  = lb0_dout;

   always_comb begin
      v0_d   = step;
      pix0_d = pix_data;
      c0_d   = pix_col;
      r0_d   = pix_row;
      v1_d   = v0_q;
      pix1_d = pix0_q;
      mid1_d = lb0_dout;
      c1_d   = c0_q;
      r1_d   = r0_q;

      m_valid_d = v1_q & (r1_q != '0);
      m_top_d   = m_top_q;
      m_mid_d   = m_mid_q;
      m_bot_d   = m_bot_q;
      m_col_d   = m_col_q;
      m_row_d   = m_row_q;
      if (m_valid_d) begin
         m_top_d = (r1_q == CW'(1)) ? mid1_q : lb1_dout;
         m_mid_d = mid1_q;
         m_bot_d = (r1_q == ROW_FLUSH) ? mid1_q : pix1_q;
         m_col_d = c1_q;
         m_row_d = RW'(r1_q - 1'b1);
      end
      m_eof_d = m_valid_d & (r1_q == ROW_FLUSH) & (c1_q == COL_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         v0_q      <= 1'b0;
         pix0_q    <= '0;
         c0_q      <= '0;
         r0_q      <= '0;
         v1_q      <= 1'b0;
         pix1_q    <= '0;
         mid1_q    <= '0;
         c1_q      <= '0;
         r1_q      <= '0;
         m_valid_q <= 1'b0;
         m_eof_q   <= 1'b0;
         m_top_q   <= '0;
         m_mid_q   <= '0;
         m_bot_q   <= '0;
         m_col_q   <= '0;
         m_row_q   <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         v0_q      <= v0_d;
         pix0_q    <= pix0_d;
         c0_q      <= c0_d;
         r0_q      <= r0_d;
         v1_q      <= v1_d;
         pix1_q    <= pix1_d;
         mid1_q    <= mid1_d;
         c1_q      <= c1_d;
         r1_q      <= r1_d;
         m_valid_q <= m_valid_d;
         m_eof_q   <= m_eof_d;
         m_top_q   <= m_top_d;
         m_mid_q   <= m_mid_d;
         m_bot_q   <= m_bot_d;
         m_col_q   <= m_col_d;
         m_row_q   <= m_row_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_eof   = m_eof_q;
   assign m_top   = m_top_q;
   assign m_mid   = m_mid_q;
   assign m_bot   = m_bot_q;
   assign m_col   = m_col_q;
   assign m_row   = m_row_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl at WIDTH=4, HEIGHT=3 with behavioural line buffers.
// Expected columns are queued when pixels are accepted; a monitor pops them on m_valid.
module tb_line_buf_ctrl;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0, s_sof = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic          lb0_ce, lb1_ce;
   logic [1:0]    lb0_addr, lb1_addr;
   logic [DW-1:0] lb0_din, lb1_din;
   logic [DW-1:0] lb0_dout = '0, lb1_dout = '0;
   logic          m_valid, m_eof;
   logic [DW-1:0] m_top, m_mid, m_bot;
   logic [1:0]    m_col, m_row;

   line_buf_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data),
      .s_ready(s_ready), .lb0_ce(lb0_ce), .lb0_addr(lb0_addr), .lb0_din(lb0_din),
      .lb0_dout(lb0_dout), .lb1_ce(lb1_ce), .lb1_addr(lb1_addr), .lb1_din(lb1_din),
      .lb1_dout(lb1_dout), .m_valid(m_valid), .m_top(m_top), .m_mid(m_mid), .m_bot(m_bot),
      .m_col(m_col), .m_row(m_row), .m_eof(m_eof));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Read-before-write RAMs: dout holds while ce is low.
   logic [DW-1:0] mem0 [W];
   logic [DW-1:0] mem1 [W];
   initial for (int i = 0; i < W; i++) begin mem0[i] = '0; mem1[i] = '0; end
   always @(posedge clk) begin
      if (lb0_ce) begin lb0_dout <= mem0[lb0_addr]; mem0[lb0_addr] <= lb0_din; end
      if (lb1_ce) begin lb1_dout <= mem1[lb1_addr]; mem1[lb1_addr] <= lb1_din; end
   end

   // Hand-computed {top,mid,bot} for pixel = 16*row + col, indexed by centre row*W + col.
   logic [23:0] ref_tab [12] = '{
      24'h000010, 24'h010111, 24'h020212, 24'h030313,
      24'h001020, 24'h011121, 24'h021222, 24'h031323,
      24'h102020, 24'h112121, 24'h122222, 24'h132323};

   typedef struct {
      logic [23:0] tup;
      int          row;
      int          col;
      logic        eof;
      int          due;
   } exp_t;
   exp_t q[$];

   int total = 0;
   int bad   = 0;

   function automatic logic [23:0] exp_tup(input logic [7:0] b, input int r, input int c);
      logic [23:0] t;
      t = ref_tab[r*W + c];
      return {t[23:16] + b, t[15:8] + b, t[7:0] + b};
   endfunction

   task automatic push_exp(input logic [7:0] b, input int r, input int c, input int t);
      exp_t e;
      e.tup = exp_tup(b, r, c);
      e.row = r;
      e.col = c;
      e.eof = (r == H-1) && (c == W-1);
      e.due = t + 3;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (m_valid) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_col got row=%0d col=%0d tup=%h, want no output",
                     m_row, m_col, {m_top, m_mid, m_bot});
         end else begin
            e = q.pop_front();
            if ({m_top, m_mid, m_bot} !== e.tup || int'(m_row) != e.row || int'(m_col) != e.col
                || m_eof !== e.eof || cyc != e.due) begin
               bad++;
               $display("FAIL column got r%0d c%0d tup=%h eof=%b cyc=%0d, want r%0d c%0d tup=%h eof=%b cyc=%0d",
                        m_row, m_col, {m_top, m_mid, m_bot}, m_eof, cyc,
                        e.row, e.col, e.tup, e.eof, e.due);
            end
         end
      end else if (m_eof) begin
         total++;
         bad++;
         $display("FAIL eof_without_valid got m_eof=1, want 0");
      end
   end

   task automatic check(input string name, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got %b want %b", name, got, want);
      end
   endtask

   task automatic send(input logic [7:0] b, input int r, input int c, input bit sof, input int gap);
      int n;
      repeat (gap) begin s_valid = 1'b0; @(negedge clk); end
      s_valid = 1'b1;
      s_sof   = sof;
      s_data  = 8'(b + 8'(16*r + c));
      #1;
      n = 0;
      while (!s_ready && n < 20) begin @(negedge clk); #1; n++; end
      if (n == 20) begin
         total++;
         bad++;
         $display("FAIL accept_timeout got s_ready=0 for 20 cycles, want 1");
      end
      if (r >= 1) push_exp(b, r-1, c, cyc);
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic flush_check(input logic [7:0] b);
      for (int k = 0; k < W; k++) begin
         #1;
         check("flush_s_ready", s_ready, 1'b0);
         check("flush_lb0_ce", lb0_ce, 1'b1);
         push_exp(b, H-1, k, cyc);
         @(negedge clk);
      end
      #1;
      check("post_flush_s_ready", s_ready, 1'b1);
   endtask

   task automatic frame(input logic [7:0] b, input bit gaps);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            send(b, r, c, (r == 0 && c == 0), gaps ? int'($urandom_range(0, 2)) : 0);
      flush_check(b);
   endtask

   initial begin
      int rc;
      // Reset with a would-be frame start present: lb0_ce must stay low.
      s_valid = 1'b1;
      s_sof   = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_lb0_ce", lb0_ce, 1'b0);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("reset_m_valid", m_valid, 1'b0);
      check("reset_lb1_ce", lb1_ce, 1'b0);
      check("reset_s_ready", s_ready, 1'b1);

      // Continuous frame
      frame(8'h00, 1'b0);

      // Non-sof pixels in IDLE are dropped
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_sof   = 1'b0;
         s_data  = 8'hEE;
         #1;
         check("idle_drop_lb0_ce", lb0_ce, 1'b0);
         @(negedge clk);
      end
      s_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Random gaps
      frame(8'h00, 1'b1);

      // Abort at (1,2) with a new frame start
      for (int c = 0; c < W; c++) send(8'h40, 0, c, c == 0, 0);
      send(8'h40, 1, 0, 1'b0, 0);
      send(8'h40, 1, 1, 1'b0, 0);
      frame(8'h80, 1'b0);

      // Reset mid-RUN with a pixel offered in the reset cycle
      for (int c = 0; c < W; c++) send(8'h20, 0, c, c == 0, 0);
      send(8'h20, 1, 0, 1'b0, 0);
      send(8'h20, 1, 1, 1'b0, 0);
      rc      = cyc;
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'h55;
      @(negedge clk);
      rst_n   = 1'b1;
      s_valid = 1'b0;
      #1;
      while (q.size() > 0 && q[q.size()-1].due >= rc + 1) void'(q.pop_back());
      check("post_reset_m_valid", m_valid, 1'b0);
      check("post_reset_lb1_ce", lb1_ce, 1'b0);
      check("post_reset_idle_ready", s_ready, 1'b1);
      @(negedge clk);
      frame(8'h00, 1'b0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d columns still pending, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish by 200000, want finish");
      $fatal(1, "watchdog");
   end
endmodule
